mcu_spi_slave: RTL
==================

MCU_SPI_SLAVE -- requirements
Module: mcu_spi_slave

Interface
REQ-001 clk  in  1  system clock; all logic in this domain.
REQ-002 reset  in  1  synchronous, active-high.
REQ-003 spi_ss_n  in  1  MCU chip select, active-low, asynchronous to clk.
REQ-004 spi_sck  in  1  MCU SPI clock (mode 0), asynchronous.
REQ-005 spi_mosi  in  1  MCU-to-FPGA serial data, MSB first.
REQ-006 spi_miso  out  1  FPGA-to-MCU serial data, MSB first.
REQ-007 tgt_strobe  out  4  one-hot byte strobe per target: bit 0 SYS, bit 1 HID, bit 2 OSD, bit 3 SDC.
REQ-008 tgt_start  out  1  qualifies tgt_strobe: byte is the command byte of a frame.
REQ-009 tgt_data  out  8  received byte, valid while any tgt_strobe bit is high.
REQ-010 sys_rdata, hid_rdata, osd_rdata, sdc_rdata  in  8 each  per-target reply bytes.
REQ-011 err_count  out  8  count of aborted frames (see Configuration).

Function
REQ-012 spi_ss_n, spi_sck and spi_mosi SHALL each pass a 2-FF synchroniser; sck edges SHALL be detected on the synchronised copy.
REQ-013 Supported spi_sck frequency SHALL be at most clk/8.
REQ-014 FSM states: WAIT_SS, IDLE, TARGET, DATA.
REQ-015 WAIT_SS -> IDLE when synchronised ss_n is high; IDLE -> TARGET on synchronised ss_n falling edge.
REQ-016 mosi SHALL be sampled on each synchronised sck rising edge into an 8-bit shift register; a 3-bit counter SHALL wrap 7->0 on completion of a byte.
REQ-017 In TARGET, the first complete byte SHALL latch the target id and not be forwarded; -> DATA.
REQ-018 In DATA, each complete byte SHALL raise exactly one tgt_strobe bit (latched id) for one clk cycle, 1 clk after the completing sck edge is detected, with tgt_data = that byte.
REQ-019 tgt_start SHALL be 1 for the first forwarded byte of a frame and 0 for all later bytes.
REQ-020 Target id > 3 SHALL produce no strobes for the whole frame; MISO SHALL return 0x00.
REQ-021 The TX shift register SHALL load the selected target's rdata exactly 2 clk cycles after each strobe, and 0x00 on entry to TARGET and DATA before the first forwarded byte.
REQ-022 spi_miso SHALL present TX bit 7 after load and shift left on each synchronised sck falling edge; spi_miso SHALL be 0 when ss_n is high.
REQ-023 Synchronised ss_n rising edge in any state SHALL return to IDLE, clear the bit counter and discard partial bits; no strobe for the partial byte.
REQ-024 ss_n rising edge with bit counter != 0 SHALL count as an aborted frame.
REQ-025 sck edges while ss_n is high SHALL be ignored.

Reset
REQ-026 On reset: state WAIT_SS, tgt_strobe 0, tgt_start 0, tgt_data 0x00, spi_miso 0, TX/RX registers 0x00, bit counter 0, err_count 0, target id 0.
REQ-027 Reset mid-frame SHALL ignore the remainder of that frame until ss_n has been observed high.

Configuration
REQ-028 Macro MCU_SPI_ERR_EN defined: err_count SHALL increment on each aborted frame, saturating at 0xFF, cleared only by reset.
REQ-029 Macro MCU_SPI_ERR_EN undefined: err_count SHALL be constant 0x00 and no counter logic SHALL exist.

Structure
REQ-030 Shared package mcu_spi_pkg SHALL hold target id constants (TGT_SYS=0, TGT_HID=1, TGT_OSD=2, TGT_SDC=3), the FSM state enum and the byte width.
REQ-031 One sub-module mcu_spi_sync (parameterised 2-FF synchroniser with edge outputs) SHALL be instantiated for ss_n, sck and mosi.
REQ-032 No other sub-modules; reply mux and FSM inline.

Verification
REQ-033 Frame 0x00,0x00,0xAA,0xBB with sys_rdata=0x5C -> tgt_strobe[0] three pulses, tgt_start only on 0x00, tgt_data 0x00/0xAA/0xBB; MISO bytes 0x00,0x00,0x5C,0x5C.
REQ-034 Frame 0x02,0x41,0x42 -> tgt_strobe[2] twice, bits 0,1,3 never set.
REQ-035 Frame 0x07,0x11,0x22 -> no strobes; MISO all 0x00.
REQ-036 ss_n rises after 5 bits of second byte -> one strobe only, FSM IDLE, err_count 1 (with macro) / 0 (without).
REQ-037 reset asserted during byte 2 with ss_n still low, then 10 more sck cycles -> no strobes until ss_n high then low; next frame 0x01,0x33 -> tgt_strobe[1] once, tgt_start 1.
REQ-038 Back-to-back frames, ss_n high for 2 sck periods, sck=clk/8 -> no lost or duplicated strobes over 256 random frames.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared definitions for the MCU SPI slave.
//   - byte width and bit-counter width
//   - target id constants (SYS, HID, OSD, SDC)
//   - frame FSM state enum
//   - helpers that decode a latched target id
package mcu_spi_pkg;

  localparam int BYTE_W  = 8;
  localparam int CNT_W   = 3;
  localparam int NUM_TGT = 4;

  localparam logic [BYTE_W-1:0] TGT_SYS = 8'd0;
  localparam logic [BYTE_W-1:0] TGT_HID = 8'd1;
  localparam logic [BYTE_W-1:0] TGT_OSD = 8'd2;
  localparam logic [BYTE_W-1:0] TGT_SDC = 8'd3;

  typedef enum logic [1:0] {
    WAIT_SS,  // after reset: wait until ss_n is seen high
    IDLE,     // deselected, waiting for ss_n to fall
    TARGET,   // receiving the command (target id) byte
    DATA      // forwarding payload bytes to the selected target
  } spi_state_e;

  // Ids 0..3 address a target; anything larger selects nobody.
  function automatic logic tgt_id_is_valid(input logic [BYTE_W-1:0] id);
    return id[BYTE_W-1:2] == '0;
  endfunction

  function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [BYTE_W-1:0] id);
    logic [NUM_TGT-1:0] oh;
    oh = '0;
    if (tgt_id_is_valid(id)) oh[id[1:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mcu_spi_sync.sv
// mcu_spi_sync: 2-FF synchroniser for one asynchronous input, plus a third
// flop so rising/falling edges of the synchronised copy can be detected.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   async_in     asynchronous input
//   sync_out     synchronised level
//   rise, fall   single-cycle pulses on edges of sync_out
// RST_VAL sets the level all three flops take during reset.
module mcu_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave: SPI mode-0 slave that routes MCU bytes to one of four
// targets. The first byte of a frame selects the target; following bytes are
// strobed to it, and the target's reply byte is shifted back on MISO.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   spi_ss_n/sck/mosi       asynchronous SPI inputs (sck <= clk/8)
//   spi_miso                serial reply, MSB first, 0 while deselected
//   tgt_strobe[3:0]         one-hot byte strobe: SYS, HID, OSD, SDC
//   tgt_start               strobe carries the first payload byte of a frame
//   tgt_data                payload byte, valid with tgt_strobe
//   sys/hid/osd/sdc_rdata   reply byte from each target
//   err_count               aborted-frame counter
// Build option: define MCU_SPI_ERR_EN to implement the saturating abort
// counter; otherwise err_count is tied to 0x00.
module mcu_spi_slave
  import mcu_spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ss_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [NUM_TGT-1:0] tgt_strobe,
  output logic              tgt_start,
  output logic [BYTE_W-1:0] tgt_data,
  input  logic [BYTE_W-1:0] sys_rdata,
  input  logic [BYTE_W-1:0] hid_rdata,
  input  logic [BYTE_W-1:0] osd_rdata,
  input  logic [BYTE_W-1:0] sdc_rdata,
  output logic [7:0]        err_count
);

  logic ss_sync, ss_rise, ss_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  // ss_n resets to 0 (selected): if reset hits mid-frame with ss_n low, no
  // fake high level or falling edge appears, so the rest of the frame is
  // ignored until ss_n genuinely goes high.
  mcu_spi_sync #(.RST_VAL(1'b0)) u_ss_sync (
    .clk(clk), .reset(reset), .async_in(spi_ss_n),
    .sync_out(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  mcu_spi_sync #(.RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .async_in(spi_sck),
    .sync_out(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  mcu_spi_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .async_in(spi_mosi),
    .sync_out(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync_outs;
  assign unused_sync_outs = ^{sck_sync, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [BYTE_W-1:0] rx_sr_q;
  logic [BYTE_W-1:0] tx_sr_q;
  logic [BYTE_W-1:0] tgt_id_q;
  logic              first_q;      // next forwarded byte is the frame's first
  logic              load_pend_q;  // strobe was high last cycle

  logic              in_frame;
  logic              sck_rise_ok;
  logic              sck_fall_ok;
  logic              byte_done;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] reply;

  assign in_frame    = (state_q == TARGET) || (state_q == DATA);
  assign sck_rise_ok = sck_rise & in_frame & ~ss_sync;
  assign sck_fall_ok = sck_fall & in_frame & ~ss_sync;
  assign rx_byte     = {rx_sr_q[BYTE_W-2:0], mosi_sync};
  assign byte_done   = sck_rise_ok && (bit_cnt_q == CNT_W'(BYTE_W - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_SS;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SS: if (ss_sync)   state_d = IDLE;
      IDLE:    if (ss_fall)   state_d = TARGET;
      TARGET:  if (byte_done) state_d = DATA;
      DATA:                   state_d = DATA;
      default:                state_d = WAIT_SS;
    endcase
    // Deselect always ends the frame, whatever state we are in.
    if (ss_rise) state_d = IDLE;
  end

  // ---------------------------------------------------------- reply mux
  always_comb begin
    reply = '0;
    case (tgt_id_q)
      TGT_SYS: reply = sys_rdata;
      TGT_HID: reply = hid_rdata;
      TGT_OSD: reply = osd_rdata;
      TGT_SDC: reply = sdc_rdata;
      default: reply = '0;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      tgt_id_q    <= '0;
      first_q     <= 1'b0;
      load_pend_q <= 1'b0;
      tgt_strobe  <= '0;
      tgt_start   <= 1'b0;
      tgt_data    <= '0;
    end else begin
      tgt_strobe  <= '0;
      tgt_start   <= 1'b0;
      load_pend_q <= |tgt_strobe;

      if (ss_rise) begin
        // Partial bits are dropped; MISO is gated low while deselected.
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
        tx_sr_q   <= '0;
      end else if ((state_q == IDLE) && ss_fall) begin
        bit_cnt_q <= '0;
        tx_sr_q   <= '0;
      end else begin
        if (sck_rise_ok) begin
          rx_sr_q   <= rx_byte;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end

        if (byte_done && (state_q == TARGET)) begin
          tgt_id_q <= rx_byte;
          first_q  <= 1'b1;
        end else if (byte_done && (state_q == DATA) && tgt_id_is_valid(tgt_id_q)) begin
          tgt_strobe <= tgt_onehot(tgt_id_q);
          tgt_start  <= first_q;
          tgt_data   <= rx_byte;
          first_q    <= 1'b0;
        end

        // The reply lands two cycles after the strobe, before the falling
        // edge that closes the byte. That closing edge (bit counter already
        // wrapped to 0) must not shift, or the reply MSB would be lost;
        // falling edges inside a byte shift as usual.
        if (byte_done && (state_q == TARGET)) begin
          tx_sr_q <= '0;
        end else if (load_pend_q) begin
          tx_sr_q <= reply;
        end else if (sck_fall_ok && (bit_cnt_q != '0)) begin
          tx_sr_q <= {tx_sr_q[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso = tx_sr_q[BYTE_W-1] & ~ss_sync;

  // ------------------------------------------------------ abort counter
`ifdef MCU_SPI_ERR_EN
  logic [7:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (ss_rise && (bit_cnt_q != '0) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
